// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the icache request and feeds IF/ID.
// A redirect that lands during an icache miss is parked until the in-flight access returns.
module ifetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic [31:0] instruction,
  output logic [31:0] pc_add4,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {FETCH, SQUASH, HALTED} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] target;
  logic        en_c, flush_c;

  assign target = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect_d = redirect_q;
    en_c       = 1'b0;
    flush_c    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
          en_c    = 1'b1;
          flush_c = 1'b1;
        end else if (redirect) begin
          en_c    = 1'b1;
          flush_c = 1'b1;
          if (ihit) begin
            pc_d = target;
          end else begin
            // Miss in flight: the address must hold, so park the target.
            redirect_d = target;
            state_d    = SQUASH;
          end
        end else if (!stall && ihit) begin
          pc_d = pc_q + 32'd4;
          en_c = 1'b1;
        end
      end
      SQUASH: begin
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          en_c       = 1'b1;
          flush_c    = 1'b1;
          redirect_d = target;
          if (ihit) begin
            pc_d    = target;
            state_d = FETCH;
          end
        end else if (ihit) begin
          pc_d    = redirect_q;
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= FETCH;
      pc_q       <= PC_INIT;
      redirect_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      redirect_q <= redirect_d;
    end
  end

  assign imemREN     = n_rst && (state_q != HALTED);
  assign ifid_en     = n_rst && en_c;
  assign ifid_flush  = n_rst && flush_c;
  assign imemaddr    = pc_q;
  assign pc          = pc_q;
  assign instruction = imemload;
  assign pc_add4     = pc_q + 32'd4;

endmodule
